// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes queue in a small FIFO and are sent LSB first,
// with back-to-back frames leaving no idle gap between stop and start bits.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [7:0]                      in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic                            uart_tx_pin,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int BIT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             push, pop, bit_last, fifo_empty;

  // Ready depends only on the current count, so a full FIFO refuses even when popping.
  assign in_ready    = (count_q != COUNT_FULL);
  assign push        = in_valid && in_ready;
  assign fifo_empty  = (count_q == '0);
  assign bit_last    = (bit_cnt_q == BIT_LAST);
  assign uart_tx_pin = tx_q;
  assign busy        = (state_q != IDLE) || !fifo_empty;
  assign fifo_count  = count_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = mem[rd_ptr_q];
          bit_cnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
      DATA: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
      STOP: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          // The pop decision sees the pre-push count: a byte arriving now waits a cycle.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
    // Line level is derived from the next state so the pin itself is a clean flop.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a frame-level line model checks every serial sample, count,
// busy and ready against a queue of accepted bytes; directed steps cover timing corners.
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data, in_data1;
  logic       in_valid, in_valid1;
  logic       in_ready, in_ready1;
  logic       tx, tx1;
  logic       busy, busy1;
  logic [4:0] fifo_count, count1;

  int vectors = 0;
  int miscompares = 0;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .uart_tx_pin(tx), .busy(busy), .fifo_count(fifo_count)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(1), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .reset(reset), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .uart_tx_pin(tx1), .busy(busy1), .fifo_count(count1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame bit k of an 8N1 frame: start, eight data bits LSB first, stop.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  // Reference model: bytes accepted but not yet started, plus the frame on the line.
  logic [7:0] exp_q[$];
  int         starts_q[$];
  int         acc_q[$];
  bit         mon_en = 1'b0;
  bit         in_frame = 1'b0;
  int         idx = 0;
  int         sn = 0;
  logic [7:0] cur = 8'h00;

  always @(negedge clk) begin
    if (mon_en) begin
      sn++;
      if (!in_frame) begin
        if (tx === 1'b0) begin
          chk("frame_has_byte", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) cur = exp_q.pop_front();
          else cur = 8'h00;
          in_frame = 1'b1;
          idx = 0;
          starts_q.push_back(sn);
        end
      end else begin
        idx++;
      end
      if (in_frame) chk("tx_bit", tx, frame_bit(cur, idx / CPB));
      chk("fifo_count", fifo_count, exp_q.size());
      chk("busy", busy, in_frame || (exp_q.size() != 0));
      chk("in_ready", in_ready, exp_q.size() != DEPTH);
      if (in_frame && idx == 10*CPB - 1) in_frame = 1'b0;
      if (reset) begin
        exp_q.delete();
        in_frame = 1'b0;
      end else if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        acc_q.push_back(sn);
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted b.
  task automatic send(input logic [7:0] b, input bit wiggle);
    int g;
    bit done;
    g = 0;
    done = 1'b0;
    in_valid = 1'b1;
    while (!done && g < 3000) begin
      in_data = (in_ready || !wiggle) ? b : 8'($urandom);
      done = in_ready;
      @(posedge clk); #2;
      g++;
    end
    in_valid = 1'b0;
    chk("send_accepted", done, 1);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy !== 1'b0 && g < 3000) begin
      @(posedge clk); #2;
      g++;
    end
    chk("drain_in_time", g < 3000, 1);
    @(posedge clk); #2;
  endtask

  task automatic clear_log();
    starts_q.delete();
    acc_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_valid1 = 1'b0;
    in_data1 = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_tx1", tx1, 1);
    chk("rst_ready1", in_ready1, 1);
    @(posedge clk); #2;

    // Single byte: pop one edge after the push, 40-cycle frame.
    clear_log();
    send(8'h55, 1'b0);
    wait_idle();
    chk("pop_latency", starts_q[0] - acc_q[0], 2);

    // Back-to-back bytes: second start bit follows the first stop bit directly.
    clear_log();
    send(8'hA5, 1'b0);
    send(8'h3C, 1'b0);
    wait_idle();
    chk("two_frames", starts_q.size(), 2);
    chk("zero_gap", starts_q[1] - starts_q[0], 40);

    // Push landing on the last stop cycle of the only frame: one extra idle cycle.
    clear_log();
    send(8'h81, 1'b0);
    repeat (40) begin @(posedge clk); #2; end
    send(8'h7E, 1'b0);
    wait_idle();
    chk("late_push_gap", starts_q[1] - starts_q[0], 41);

    // Twenty bytes against a 16-deep queue.
    clear_log();
    for (int i = 0; i < 17; i++) send(8'(8'h10 + i), 1'b0);
    @(negedge clk);
    chk("full_count", fifo_count, 16);
    chk("full_ready", in_ready, 0);
    @(posedge clk); #2;
    for (int i = 17; i < 20; i++) send(8'(8'h10 + i), 1'b0);
    wait_idle();
    chk("twenty_frames", starts_q.size(), 20);

    // Data changing while refused: only the value on the accepting edge counts.
    for (int i = 0; i < 17; i++) send(8'($urandom), 1'b0);
    send(8'hC3, 1'b1);
    wait_idle();

    // Random traffic with random gaps and random data wiggle while stalled.
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 45)) begin @(posedge clk); #2; end
      send(8'($urandom), 1'($urandom_range(0, 1)));
    end
    wait_idle();

    // Reset mid-DATA with three bytes queued.
    clear_log();
    for (int i = 0; i < 4; i++) send(8'(8'hE0 + i), 1'b0);
    repeat (10) begin @(posedge clk); #2; end
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 1);
    @(posedge clk); #2;
    repeat (100) begin @(posedge clk); #2; end
    chk("no_frames_after_reset", starts_q.size(), 1);

    // One clock per bit: 0xFF then 0x00 as two gapless 10-cycle frames.
    in_valid1 = 1'b1;
    in_data1 = 8'hFF;
    @(posedge clk); #2;
    in_data1 = 8'h00;
    @(posedge clk); #2;
    in_valid1 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("cpb1_tx", tx1, (k < 10) ? frame_bit(8'hFF, k) : frame_bit(8'h00, k - 10));
    end
    @(negedge clk);
    chk("cpb1_idle_tx", tx1, 1);
    chk("cpb1_idle_busy", busy1, 0);
    chk("cpb1_idle_count", count1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered UART transmitter for the delay-line test harness: sends 8N1 frames on uart_tx_pin from bytes queued on a valid/ready stream.
- The harness measurement logic pushes result bytes into an internal FIFO; the block serialises them back to the host.
- It is the transmit counterpart of the harness UART receive path and runs on the PLL clock domain.

Parameters:
- CLKS_PER_BIT, 104, clk cycles per UART bit (12 MHz / 115200); legal range >= 1.
- FIFO_DEPTH, 16, byte entries in the queue; must be a power of two, >= 2.

Ports:
- clk  input  1  system clock (PLL output).
- reset  input  1  synchronous, active-high reset.
- in_data  input  8  byte to queue.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  FIFO can accept a byte this cycle.
- uart_tx_pin  output  1  serial line; idles high.
- busy  output  1  FIFO non-empty or frame in progress.
- fifo_count  output  $clog2(FIFO_DEPTH+1)  bytes currently queued, excluding the byte in flight.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset).
- Reset: uart_tx_pin=1, in_ready=1, busy=0, fifo_count=0, FSM=IDLE. The FIFO is emptied and any frame in flight is abandoned; the line is high on the cycle after reset is sampled.
- Push: a byte is accepted when in_valid && in_ready at a rising edge. in_ready = (fifo_count != FIFO_DEPTH), registered-free (combinational from count).
- Full FIFO: in_ready=0 even if a pop occurs in the same cycle. No push-through-when-full.
- Simultaneous push and pop on a non-full FIFO: both take effect; fifo_count is unchanged.
- FIFO order is strict first-in first-out. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP. A bit counter (0..CLKS_PER_BIT-1) and a bit index (0..7) are kept.
- IDLE: line=1. If the FIFO is non-empty at an edge, pop the head into the shift register and go to START.
  - Latency: a byte pushed at edge N into an empty, idle block pops at N+1; uart_tx_pin goes low after edge N+1.
- START: line=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: line=shift[0] (LSB first). Each bit is held CLKS_PER_BIT cycles. After bit 7, go to STOP.
- STOP: line=1 for CLKS_PER_BIT cycles. On the last stop cycle:
  - If the FIFO is non-empty, pop and go directly to START. Zero idle gap, so a frame is exactly 10*CLKS_PER_BIT cycles.
  - Otherwise go to IDLE.
- A push of the only pending byte on the last STOP cycle is not visible to that pop decision. It pops from IDLE on the next cycle (one extra idle-high cycle).
- busy = (state != IDLE) || (fifo_count != 0).
- CLKS_PER_BIT=1: each state lasts exactly one cycle; the bit counter must not underflow.
- in_data is sampled only on an accepted push; it is ignored otherwise.

Test Plan:
- CLKS_PER_BIT=4, push 0x55 once -> line low 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles; busy falls after cycle 40 of the frame; fifo_count returns to 0.
- Push 0xA5 and 0x3C on consecutive cycles -> two frames of 40 cycles each, the second start bit immediately after the first stop bit; data LSB-first 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
- Hold in_valid high with 20 distinct bytes while the first frame runs -> the first byte pops and 16 are queued; in_ready=0 with fifo_count=16; the remaining bytes are accepted only as slots free; all 20 are received in order with no loss or duplication.
- Assert reset for one cycle mid-DATA of a frame with 3 bytes queued -> uart_tx_pin=1 on the next cycle, fifo_count=0, busy=0; no further frames appear.
- CLKS_PER_BIT=1, push 0xFF then 0x00 -> 10-cycle frames: 0,1×8,1 then 0,0×8,1, with no gap between them.
- in_valid asserted with in_ready=0, and in_data changed while waiting -> only the value present on the accepting edge is transmitted.
